div: RTL and testbench



---
 rtl/div_pkg.sv | 22 ++
 rtl/div.sv | 136 +++++++++++++
 tb/tb_div.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the EX-stage divider: bus widths, FSM state
// encodings and the ready/start handshake levels.
package div_pkg;

  localparam int unsigned RegWidth       = 32;
  localparam int unsigned DoubleRegWidth = 64;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider serving DIV/DIVU in the EX stage.
// Returns {remainder, quotient}; ready_o stays high while start_i is held.
// Configuration macro: DIV_SIGNED_EN -- when defined, signed_div_i selects
// signed division (absolute-value operands plus sign fixup); when undefined
// every division is unsigned and the sign logic is not built.
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [RegWidth-1:0]       opdata1_i,
  input  logic [RegWidth-1:0]       opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DoubleRegWidth-1:0] result_o,
  output logic                      ready_o
);

  div_state_e                state_q;
  logic [5:0]                cnt_q;
  // Bit 64 of the 65-bit working value is always zero between iterations,
  // so only the low 64 bits are stored.
  logic [63:0]               work_q;
  logic [RegWidth-1:0]       divisor_q;
  logic [DoubleRegWidth-1:0] result_q;
  logic                      ready_q;

  logic [64:0]               shifted;
  logic [32:0]               diff;
  logic [63:0]               work_d;
  logic [RegWidth-1:0]       dividend_in;
  logic [RegWidth-1:0]       divisor_in;
  logic [DoubleRegWidth-1:0] result_d;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q;
  logic neg_rem_q;
  logic neg_quot_in;
  logic neg_rem_in;
`else
  logic unused_signed_div;
  assign unused_signed_div = signed_div_i;
`endif

  // One restoring step plus operand conditioning and final sign fixup.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    shifted = {work_q, 1'b0};
    diff    = shifted[64:32] - {1'b0, divisor_q};
    work_d  = shifted[63:0];
    if (!diff[32]) work_d = {diff[31:0], shifted[31:1], 1'b1};

`ifdef DIV_SIGNED_EN
    dividend_in = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    divisor_in  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    neg_quot_in = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
    neg_rem_in  = signed_div_i && opdata1_i[31];
    result_d    = {(neg_rem_q  ? -work_q[63:32] : work_q[63:32]),
                   (neg_quot_q ? -work_q[31:0]  : work_q[31:0])};
`else
    dividend_in = opdata1_i;
    divisor_in  = opdata2_i;
    result_d    = work_q;
`endif
  end

  // Divider FSM: accept, iterate, fix up, and hold the result until start drops.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              state_q <= DivByZero;
            end else begin
              state_q   <= DivOn;
              cnt_q     <= '0;
              work_q    <= {32'b0, dividend_in};
              divisor_q <= divisor_in;
`ifdef DIV_SIGNED_EN
              neg_quot_q <= neg_quot_in;
              neg_rem_q  <= neg_rem_in;
`endif
            end
          end
        end
        DivByZero: begin
          state_q  <= DivEnd;
          result_q <= '0;
          ready_q  <= DivResultReady;
        end
        DivOn: begin
          if (annul_i || start_i == DivStop) begin
            state_q <= DivFree;
            cnt_q   <= '0;
          end else if (cnt_q != 6'd32) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
          end else begin
            state_q  <= DivEnd;
            cnt_q    <= '0;
            result_q <= result_d;
            ready_q  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state_q  <= DivFree;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized
// divisions compared against a plain-arithmetic reference model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks_cnt = 0;
  int errors_cnt = 0;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign,
  // divide-by-zero yields zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s && SignedEn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one division, hold start until ready, check latency/result,
  // then release start and check that the result clears.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    int edges;
    int exp_edges;
    logic [63:0] exp;
    exp       = ref_div(a, b, s);
    exp_edges = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    edges        = 0;
    while (!ready_o && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check({tag, "_result"}, result_o, exp);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_clear"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    int seen;
    logic [63:0] held;
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_div("divu_5_0", 32'd5, 32'd0, 1'b0);
    run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("divu_max", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div("divu_small", 32'd3, 32'd10, 1'b0);

    // Annul at iteration 10: no result may appear.
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0);

    // annul_i is ignored once the result is held.
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd33; start_i = 1'b1;
    seen = 0;
    while (!ready_o && seen < 60) begin
      @(posedge clk);
      #1;
      seen++;
    end
    held = result_o;
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("end_annul_ready", {63'd0, ready_o}, 64'd1);
    check("end_annul_result", result_o, ref_div(32'd1000, 32'd33, 1'b0));
    check("end_annul_stable", result_o, held);
    // Reset while the result is held clears both outputs.
    @(negedge clk);
    annul_i = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_end", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;

    // Reset mid-iteration: outputs zero, and no stale result afterwards.
    @(negedge clk);
    opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_on", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    run_div("after_rst", 32'd81, 32'd9, 1'b0);

    // Randomized operands, with a bias toward zero and small divisors.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 16);
        2: b = $urandom & 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_div("rand", a, b, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
